// File: rtl/object_plotter_pkg.sv
// rtl/object_plotter_pkg.sv - object indices, screen size and state encoding shared with the sequencer
package object_plotter_pkg;

  localparam logic [3:0] OBJ_PLAYER = 4'd0;
  localparam logic [3:0] OBJ_ENEMY1 = 4'd1;
  localparam logic [3:0] OBJ_ENEMY2 = 4'd2;
  localparam logic [3:0] OBJ_ENEMY3 = 4'd3;
  localparam logic [3:0] OBJ_ENEMY4 = 4'd4;
  localparam logic [3:0] OBJ_BULLET = 4'd5;
  localparam int         NUM_OBJ    = 6;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_LATCH = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } plot_state_t;

  function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
    return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/object_plotter_rect_scan.sv
// rtl/object_plotter_rect_scan.sv - row-major W x H pixel counter; the first pixel is produced in the start cycle
module rect_scan #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_start,
  input  logic [CW-1:0] i_w,
  input  logic [CW-1:0] i_h,
  output logic [CW-1:0] o_cx,
  output logic [CW-1:0] o_cy,
  output logic          o_last,
  output logic          o_busy
);

  logic [CW-1:0] r_cx;
  logic [CW-1:0] r_cy;
  logic [CW-1:0] r_w;
  logic [CW-1:0] r_h;
  logic          r_busy;
  logic [CW-1:0] w_w;
  logic [CW-1:0] w_h;
  logic          w_row_end;

  assign o_busy    = i_start | r_busy;
  assign o_cx      = i_start ? '0 : r_cx;
  assign o_cy      = i_start ? '0 : r_cy;
  assign w_w       = i_start ? i_w : r_w;
  assign w_h       = i_start ? i_h : r_h;
  assign w_row_end = (o_cx == w_w - CW'(1));
  assign o_last    = o_busy && w_row_end && (o_cy == w_h - CW'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cx   <= '0;
      r_cy   <= '0;
      r_w    <= '0;
      r_h    <= '0;
      r_busy <= 1'b0;
    end else begin
      if (i_start) begin
        r_w <= i_w;
        r_h <= i_h;
      end
      if (o_busy) begin
        r_busy <= !o_last;
        if (w_row_end) begin
          r_cx <= '0;
          r_cy <= o_cy + CW'(1);
        end else begin
          r_cx <= o_cx + CW'(1);
          r_cy <= o_cy;
        end
      end
    end
  end

endmodule

// File: rtl/object_plotter.sv
// rtl/object_plotter.sv - erases and redraws one selected object rectangle per request, one pixel per clock
module object_plotter
  import object_plotter_pkg::*;
#(
  parameter int         PLAYER_W   = 8,
  parameter int         PLAYER_H   = 8,
  parameter int         ENEMY_W    = 8,
  parameter int         ENEMY_H    = 6,
  parameter int         BULLET_W   = 1,
  parameter int         BULLET_H   = 3,
  parameter logic [2:0] PLAYER_COL = 3'b010,
  parameter logic [2:0] ENEMY_COL  = 3'b100,
  parameter logic [2:0] BULLET_COL = 3'b111,
  parameter logic [2:0] BG_COL     = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  draw_sel,
  input  logic [5:0]  obj_active,
  input  logic [47:0] pos_x_flat,
  input  logic [41:0] pos_y_flat,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        done
);

  localparam int CW = 4;

  plot_state_t r_state;
  plot_state_t w_state_nxt;

  logic [3:0]    r_sel;
  logic          r_active;
  logic [7:0]    r_pos_x;
  logic [6:0]    r_pos_y;
  logic [7:0]    r_prev_x [8];
  logic [6:0]    r_prev_y [8];
  logic [7:0]    r_prev_valid;
  logic [7:0]    r_base_x;
  logic [6:0]    r_base_y;
  logic [2:0]    r_col;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic [2:0]    r_colour;
  logic          r_plot;
  logic          r_done;
  logic          r_out_last;

  logic [3:0]    w_sel;
  logic          w_sel_ok;
  logic [2:0]    w_idx;
  logic [63:0]   w_pos_x_pad;
  logic [55:0]   w_pos_y_pad;
  logic [7:0]    w_act_pad;
  logic [7:0]    w_in_x;
  logic [6:0]    w_in_y;
  logic          w_cur_active;
  logic [7:0]    w_cur_x;
  logic [6:0]    w_cur_y;
  logic [CW-1:0] w_w;
  logic [CW-1:0] w_h;
  logic [2:0]    w_draw_col;
  logic          w_start;
  logic          w_start_draw;
  logic [CW-1:0] w_cx;
  logic [CW-1:0] w_cy;
  logic          w_last;
  logic          w_busy;
  logic [7:0]    w_base_x;
  logic [6:0]    w_base_y;
  logic [2:0]    w_col;
  logic [8:0]    w_px;
  logic [7:0]    w_py;

  // While latching, the live inputs steer the scanner so its first pixel is ready on the next edge
  assign w_sel        = (r_state == ST_LATCH) ? draw_sel : r_sel;
  assign w_sel_ok     = (w_sel <= OBJ_BULLET);
  assign w_idx        = w_sel[2:0];
  assign w_pos_x_pad  = {16'd0, pos_x_flat};
  assign w_pos_y_pad  = {14'd0, pos_y_flat};
  assign w_act_pad    = {2'd0, obj_active};
  assign w_in_x       = w_pos_x_pad[{w_idx, 3'b000} +: 8];
  assign w_in_y       = w_pos_y_pad[{3'b000, w_idx} * 6'd7 +: 7];
  assign w_cur_active = (r_state == ST_LATCH) ? (w_sel_ok && w_act_pad[w_idx]) : r_active;
  assign w_cur_x      = (r_state == ST_LATCH) ? w_in_x : r_pos_x;
  assign w_cur_y      = (r_state == ST_LATCH) ? w_in_y : r_pos_y;

  always_comb begin
    w_w        = '0;
    w_h        = '0;
    w_draw_col = BG_COL;
    case (w_sel)
      OBJ_PLAYER: begin
        w_w        = CW'(PLAYER_W);
        w_h        = CW'(PLAYER_H);
        w_draw_col = PLAYER_COL;
      end
      OBJ_ENEMY1, OBJ_ENEMY2, OBJ_ENEMY3, OBJ_ENEMY4: begin
        w_w        = CW'(ENEMY_W);
        w_h        = CW'(ENEMY_H);
        w_draw_col = ENEMY_COL;
      end
      OBJ_BULLET: begin
        w_w        = CW'(BULLET_W);
        w_h        = CW'(BULLET_H);
        w_draw_col = BULLET_COL;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_start_draw = 1'b0;
    case (r_state)
      ST_LATCH: begin
        if (!w_sel_ok) begin
          w_state_nxt = ST_DONE;
        end else if (r_prev_valid[w_idx]) begin
          w_state_nxt = ST_ERASE;
          w_start     = 1'b1;
        end else if (w_cur_active) begin
          w_state_nxt  = ST_DRAW;
          w_start      = 1'b1;
          w_start_draw = 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_ERASE: begin
        if (r_out_last) begin
          if (r_active) begin
            w_state_nxt  = ST_DRAW;
            w_start      = 1'b1;
            w_start_draw = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DRAW: begin
        if (r_out_last) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_LATCH;
      default:  w_state_nxt = ST_LATCH;
    endcase
  end

  rect_scan #(.CW(CW)) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .i_start (w_start),
    .i_w     (w_w),
    .i_h     (w_h),
    .o_cx    (w_cx),
    .o_cy    (w_cy),
    .o_last  (w_last),
    .o_busy  (w_busy)
  );

  assign w_base_x = w_start ? (w_start_draw ? w_cur_x : r_prev_x[w_idx]) : r_base_x;
  assign w_base_y = w_start ? (w_start_draw ? w_cur_y : r_prev_y[w_idx]) : r_base_y;
  assign w_col    = w_start ? (w_start_draw ? w_draw_col : BG_COL) : r_col;
  assign w_px     = {1'b0, w_base_x} + 9'(w_cx);
  assign w_py     = {1'b0, w_base_y} + 8'(w_cy);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_LATCH;
      r_sel        <= '0;
      r_active     <= 1'b0;
      r_pos_x      <= '0;
      r_pos_y      <= '0;
      r_prev_valid <= '0;
      r_base_x     <= '0;
      r_base_y     <= '0;
      r_col        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_plot       <= 1'b0;
      r_done       <= 1'b0;
      r_out_last   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_prev_x[i] <= '0;
        r_prev_y[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_px[7:0];
      r_y        <= w_py[6:0];
      r_colour   <= w_col;
      r_plot     <= w_busy && on_screen(w_px, w_py);
      r_done     <= (w_state_nxt == ST_DONE);
      r_out_last <= w_last;
      if (r_state == ST_LATCH) begin
        r_sel    <= draw_sel;
        r_active <= w_cur_active;
        r_pos_x  <= w_in_x;
        r_pos_y  <= w_in_y;
      end
      if (w_start) begin
        r_base_x <= w_base_x;
        r_base_y <= w_base_y;
        r_col    <= w_col;
      end
      if (r_state == ST_ERASE && r_out_last && !r_active) begin
        r_prev_valid[r_sel[2:0]] <= 1'b0;
      end
      if (r_state == ST_DRAW && r_out_last) begin
        r_prev_x[r_sel[2:0]]     <= r_pos_x;
        r_prev_y[r_sel[2:0]]     <= r_pos_y;
        r_prev_valid[r_sel[2:0]] <= 1'b1;
      end
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign done   = r_done;

endmodule

// File: tb/tb_object_plotter.sv
// tb/tb_object_plotter.sv - scoreboard bench: expected pixels queued per select, popped on each plot
module tb_object_plotter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  draw_sel;
  logic [5:0]  obj_active;
  logic [47:0] pos_x_flat;
  logic [41:0] pos_y_flat;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        done;

  always #5 clk = ~clk;

  object_plotter dut (
    .clk        (clk),
    .resetn     (resetn),
    .draw_sel   (draw_sel),
    .obj_active (obj_active),
    .pos_x_flat (pos_x_flat),
    .pos_y_flat (pos_y_flat),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .done       (done)
  );

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_valid [6];
  int   m_px    [6];
  int   m_py    [6];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int obj_w(input int s);
    return (s == 5) ? 1 : 8;
  endfunction

  function automatic int obj_h(input int s);
    return (s == 0) ? 8 : (s == 5) ? 3 : 6;
  endfunction

  function automatic logic [2:0] obj_c(input int s);
    return (s == 0) ? 3'b010 : (s == 5) ? 3'b111 : 3'b100;
  endfunction

  task automatic push_rect(input int ox, input int oy, input int s, input logic [2:0] c);
    for (int cy = 0; cy < obj_h(s); cy++) begin
      for (int cx = 0; cx < obj_w(s); cx++) begin
        if (ox + cx < 160 && oy + cy < 120) exp_q.push_back({8'(ox + cx), 7'(oy + cy), c});
      end
    end
  endtask

  task automatic drive(input int s, input bit act, input int px, input int py);
    draw_sel   = 4'(s);
    obj_active = 6'($urandom);
    pos_x_flat = {16'($urandom), $urandom};
    pos_y_flat = {10'($urandom), $urandom};
    if (s < 6) begin
      obj_active[s]        = act;
      pos_x_flat[8*s +: 8] = 8'(px);
      pos_y_flat[7*s +: 7] = 7'(py);
    end
  endtask

  // Called in the LATCH cycle; returns in the LATCH cycle of the next select.
  task automatic run_sel(input string tag, input int s, input bit act, input int px, input int py);
    int exp_cyc;
    int cyc;
    bit seen;
    exp_q.delete();
    drive(s, act, px, py);
    exp_cyc = 2;
    if (s < 6) begin
      if (m_valid[s]) begin
        push_rect(m_px[s], m_py[s], s, 3'b000);
        exp_cyc += obj_w(s) * obj_h(s);
      end
      if (act) begin
        push_rect(px, py, s, obj_c(s));
        exp_cyc += obj_w(s) * obj_h(s);
        m_px[s] = px;
        m_py[s] = py;
      end
      m_valid[s] = act;
    end
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 4) drive($urandom_range(0, 15), 1'b1, $urandom_range(0, 255), $urandom_range(0, 127));
      if (plot) begin
        if (exp_q.size() == 0) begin
          check_eq({tag, "_extra_plot"}, 32'(plot), 32'(exp_q.size() != 0));
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          check_eq({tag, "_pixel"}, 32'({x, y, colour}), 32'(e));
        end
      end
      if (done) begin
        seen = 1'b1;
        check_eq({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_plot_at_done"}, 32'(plot), 32'(0));
        check_eq({tag, "_missing_pixels"}, 32'(exp_q.size()), 32'(0));
      end
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'(cyc), 32'(exp_cyc));
    @(negedge clk);
  endtask

  initial begin
    resetn     = 1'b0;
    draw_sel   = '0;
    obj_active = '0;
    pos_x_flat = '0;
    pos_y_flat = '0;
    for (int i = 0; i < 6; i++) m_valid[i] = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check_eq("reset_xyc", 32'({x, y, colour}), 32'(0));
    check_eq("reset_plot_done", 32'({plot, done}), 32'(0));

    run_sel("player_first", 0, 1'b1, 10, 20);
    run_sel("player_move", 0, 1'b1, 12, 20);
    run_sel("bullet_draw", 5, 1'b1, 50, 50);
    run_sel("bullet_kill", 5, 1'b0, 50, 50);
    run_sel("bullet_gone", 5, 1'b0, 50, 50);
    run_sel("enemy_clip", 1, 1'b1, 156, 118);
    run_sel("bad_sel", 9, 1'b1, 0, 0);
    run_sel("enemy_clip_again", 1, 1'b1, 156, 118);
    for (int k = 0; k < 10; k++) begin
      run_sel("random", $urandom_range(0, 5), 1'($urandom_range(0, 3) != 0),
              $urandom_range(0, 170), $urandom_range(0, 125));
    end

    drive(2, 1'b1, 30, 40);
    repeat (20) @(negedge clk);
    check_eq("pre_reset_plot", 32'(plot), 32'(1));
    resetn = 1'b0;
    @(negedge clk);
    check_eq("midscan_reset_plot", 32'(plot), 32'(0));
    check_eq("midscan_reset_done", 32'(done), 32'(0));
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) m_valid[i] = 1'b0;
    run_sel("after_reset", 0, 1'b1, 30, 40);
    run_sel("after_reset_enemy", 2, 1'b1, 30, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
